// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: counts enabled clocks and pulses tick on the last
// count of each period. A period of 0 behaves like 1 (tick every clock).
module led_seq_prescaler #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    tick
);

  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] cnt_d;
  logic [PERIOD_WIDTH-1:0] last_s;

  // Terminal count and next count value
  always_comb begin
    cnt_d = cnt_q;
    if (period == {PERIOD_WIDTH{1'b0}}) begin
      last_s = {PERIOD_WIDTH{1'b0}};
    end else begin
      last_s = period - PERIOD_WIDTH'(1);
    end
    tick = enable && (cnt_q == last_s);
    if (clear) begin
      cnt_d = {PERIOD_WIDTH{1'b0}};
    end else if (tick) begin
      cnt_d = {PERIOD_WIDTH{1'b0}};
    end else if (enable) begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {PERIOD_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer: host programs pattern/mode/period, the
// block then steps the LED bank autonomously (static, blink, rotate).
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int                      DATA_WIDTH     = 8,
  parameter int                      PERIOD_WIDTH   = 24,
  parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = 24'd5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  busy
);

  logic [2:0]              ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]   pattern_q, pattern_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   cur_q, cur_d;
  logic [7:0]              step_cnt_q, step_cnt_d;
  logic                    phase_q, phase_d;
  logic                    wr_s, reload_s, run_ok_q_s, run_ok_d_s, tick_s;
  logic                    unused_wdata_s;

  assign wr_s           = chipselect && !write_n;
  assign unused_wdata_s = ^writedata[31:PERIOD_WIDTH];

  // Register file write decode
  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    if (wr_s) begin
      case (address)
        ADDR_CTRL:    ctrl_d    = writedata[2:0];
        ADDR_PATTERN: pattern_d = writedata[DATA_WIDTH-1:0];
        ADDR_PERIOD:  period_d  = writedata[PERIOD_WIDTH-1:0];
        default:      ctrl_d    = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Any write other than a CTRL write keeping the same mode forces a reload.
  assign reload_s   = wr_s && ((address != ADDR_CTRL) || (writedata[2:1] != ctrl_q[2:1]));
  assign run_ok_q_s = ctrl_q[0] && (ctrl_q[2:1] != 2'd0);
  assign run_ok_d_s = ctrl_d[0] && (ctrl_d[2:1] != 2'd0);

  led_seq_prescaler #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_prescaler (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear  (state_q != ST_RUN),
    .enable (state_q == ST_RUN),
    .period (period_q),
    .tick   (tick_s)
  );

  // Sequencer FSM next-state and datapath
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      ST_IDLE: begin
        cur_d = pattern_q;
        if (run_ok_q_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cur_d      = pattern_q;
        step_cnt_d = 8'd0;
        phase_d    = 1'b1;
        if (!run_ok_d_s) begin
          state_d = ST_IDLE;
          cur_d   = pattern_d;
        end else if (reload_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!run_ok_d_s) begin
          state_d = ST_IDLE;
          cur_d   = pattern_d;
        end else if (reload_s) begin
          state_d = ST_LOAD;
        end else if (tick_s) begin
          step_cnt_d = step_cnt_q + 8'd1;
          phase_d    = !phase_q;
          case (mode_e'(ctrl_q[2:1]))
            MODE_BLINK: cur_d = phase_q ? {DATA_WIDTH{1'b0}} : pattern_q;
            MODE_ROTL:  cur_d = {cur_q[DATA_WIDTH-2:0], cur_q[DATA_WIDTH-1]};
            MODE_ROTR:  cur_d = {cur_q[0], cur_q[DATA_WIDTH-1:1]};
            default:    cur_d = cur_q;
          endcase
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration and LED registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= 3'd0;
      pattern_q  <= {DATA_WIDTH{1'b0}};
      period_q   <= DEFAULT_PERIOD;
      state_q    <= ST_IDLE;
      cur_q      <= {DATA_WIDTH{1'b0}};
      step_cnt_q <= 8'd0;
      phase_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      pattern_q  <= pattern_d;
      period_q   <= period_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign out_port = cur_q;
  assign busy     = (state_q == ST_RUN);

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:    readdata = {29'd0, ctrl_q};
      ADDR_PATTERN: readdata = {{(32-DATA_WIDTH){1'b0}}, pattern_q};
      ADDR_PERIOD:  readdata = {{(32-PERIOD_WIDTH){1'b0}}, period_q};
      ADDR_STATUS:  readdata = {22'd0, state_q == ST_RUN, step_cnt_q, 1'b0};
      default:      readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer.
module tb_led_pattern_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        busy;

  int n_cmp;
  int n_fail;

  led_pattern_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;

    vecs[0] = '{"rst_ctrl",    1'b0, 2'd0, 32'h0,         32'h0,        8'h00, 1'b0};
    vecs[1] = '{"rst_pattern", 1'b0, 2'd1, 32'h0,         32'h0,        8'h00, 1'b0};
    vecs[2] = '{"rst_period",  1'b0, 2'd2, 32'h0,         32'd5000000,  8'h00, 1'b0};
    vecs[3] = '{"rst_status",  1'b0, 2'd3, 32'h0,         32'h0,        8'h00, 1'b0};
    vecs[4] = '{"wr_pattern",  1'b1, 2'd1, 32'hFFFFFF5A,  32'h5A,       8'h5A, 1'b0};
    vecs[5] = '{"wr_period",   1'b1, 2'd2, 32'hFF123456,  32'h123456,   8'h5A, 1'b0};
    vecs[6] = '{"wr_ctrl_hi",  1'b1, 2'd0, 32'hFFFFFFF8,  32'h0,        8'h5A, 1'b0};
    vecs[7] = '{"wr_ctrl_dis", 1'b1, 2'd0, 32'h00000006,  32'h6,        8'h5A, 1'b0};
    vecs[8] = '{"wr_restart",  1'b1, 2'd3, 32'hFFFFFFFF,  32'h0,        8'h5A, 1'b0};
    vecs[9] = '{"wr_ctrl_0",   1'b1, 2'd0, 32'h0,         32'h0,        8'h5A, 1'b0};

    #12;
    @(negedge clk);
    reset_n = 1'b1;
    step(1);

    // Register access vectors while idle
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) begin
        bus_wr(vecs[i].addr, vecs[i].wdata);
        step(1);
      end
      rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp_rd);
      chk({vecs[i].name, "_out"}, {24'd0, out_port}, {24'd0, vecs[i].exp_out});
      chk({vecs[i].name, "_busy"}, {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end

    // Rotate-left, PERIOD 4
    bus_wr(2'd1, 32'h81);
    bus_wr(2'd2, 32'd4);
    bus_wr(2'd0, 32'h5);
    step(2);
    chk("rotl_busy", {31'd0, busy}, 32'd1);
    chk("rotl_out0", {24'd0, out_port}, 32'h81);
    step(3);
    chk("rotl_hold", {24'd0, out_port}, 32'h81);
    step(1);
    chk("rotl_out1", {24'd0, out_port}, 32'h03);
    step(4);
    chk("rotl_out2", {24'd0, out_port}, 32'h06);
    step(4);
    chk("rotl_out3", {24'd0, out_port}, 32'h0C);
    rd_chk("rotl_status", 2'd3, 32'h206);
    rd_chk("rotl_ctrl", 2'd0, 32'h5);
    bus_wr(2'd0, 32'h0);
    chk("stop_out", {24'd0, out_port}, 32'h81);
    chk("stop_busy", {31'd0, busy}, 32'd0);

    // Blink, PERIOD 2
    bus_wr(2'd1, 32'hA5);
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h3);
    step(2);
    chk("blink_0", {24'd0, out_port}, 32'hA5);
    step(1);
    chk("blink_1", {24'd0, out_port}, 32'hA5);
    step(1);
    chk("blink_2", {24'd0, out_port}, 32'h00);
    step(1);
    chk("blink_3", {24'd0, out_port}, 32'h00);
    step(1);
    chk("blink_4", {24'd0, out_port}, 32'hA5);
    step(2);
    chk("blink_6", {24'd0, out_port}, 32'h00);
    bus_wr(2'd0, 32'h0);
    chk("blink_off_out", {24'd0, out_port}, 32'hA5);
    chk("blink_off_busy", {31'd0, busy}, 32'd0);

    // Rotate-right, PERIOD 0 steps every clock; step_cnt wraps
    bus_wr(2'd1, 32'h01);
    bus_wr(2'd2, 32'd0);
    bus_wr(2'd0, 32'h7);
    rd_chk("rotr_period0", 2'd2, 32'd0);
    step(2);
    chk("rotr_out0", {24'd0, out_port}, 32'h01);
    step(1);
    chk("rotr_out1", {24'd0, out_port}, 32'h80);
    step(1);
    chk("rotr_out2", {24'd0, out_port}, 32'h40);
    step(1);
    chk("rotr_out3", {24'd0, out_port}, 32'h20);
    rd_chk("rotr_status3", 2'd3, 32'h206);
    step(253);
    rd_chk("rotr_wrap", 2'd3, 32'h200);
    chk("rotr_out256", {24'd0, out_port}, 32'h01);

    // PATTERN write on the exact tick cycle, PERIOD 10
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'h11);
    bus_wr(2'd2, 32'd10);
    bus_wr(2'd0, 32'h5);
    step(2);
    chk("tick_busy", {31'd0, busy}, 32'd1);
    step(9);
    chk("tick_pre", {24'd0, out_port}, 32'h11);
    bus_wr(2'd1, 32'hF0);
    chk("tick_no_step", {24'd0, out_port}, 32'h11);
    step(1);
    chk("tick_load", {24'd0, out_port}, 32'hF0);
    chk("tick_busy2", {31'd0, busy}, 32'd1);
    step(9);
    chk("tick_hold", {24'd0, out_port}, 32'hF0);
    step(1);
    chk("tick_next", {24'd0, out_port}, 32'hE1);
    rd_chk("tick_status", 2'd3, 32'h202);

    // Asynchronous reset mid-RUN
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out", {24'd0, out_port}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    rd_chk("arst_ctrl", 2'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    rd_chk("arst_period", 2'd2, 32'd5000000);
    chk("arst_out2", {24'd0, out_port}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
